// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Sequential instruction fetch front end. Issues read requests to a synchronous
//   instruction ROM, buffers each returned word with its PC in a DEPTH-entry FIFO,
//   and presents the FIFO head to decode over a valid/ready handshake.
//   A redirect loads a new (step-aligned) PC and flushes the FIFO and any in-flight
//   response. A stall (fetch_en=0) holds the PC while the FIFO keeps draining.
//
// Ports
//   clk            in   clock, all state updates on posedge
//   rst            in   synchronous active-low reset
//   fetch_en       in   allow new ROM requests
//   redirect_valid in   load redirect_pc and flush
//   redirect_pc    in   new PC (low bits below the step size are ignored)
//   rom_en         out  ROM read request this cycle
//   rom_addr       out  ROM read address (current PC)
//   rom_data       in   ROM word, valid one cycle after rom_en
//   inst_valid     out  FIFO head valid
//   inst_ready     in   decode accepts head
//   inst           out  head instruction word (0 when empty)
//   inst_pc        out  head PC (0 when empty)
//   pc_next        out  current PC + PC_STEP, wrapping
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_next
);

  localparam int unsigned       PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CntW      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] StepVal   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(PC_STEP - 1));
  localparam logic [CntW:0]     DepthCmp  = (CntW + 1)'(DEPTH);
  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(DEPTH - 1);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] issue_pc_q;
  logic              inflight_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic              do_redirect;
  logic [CntW:0]     credits_used;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Credits count registered occupancy plus the outstanding response, so a push
  // can never land on a full FIFO. A same-cycle pop deliberately frees nothing.
  assign credits_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign do_redirect  = (state_q == StRun) && redirect_valid;

  assign issue = (state_q == StRun) && fetch_en && !redirect_valid && (credits_used < DepthCmp);
  assign push  = inflight_q && !redirect_valid;
  assign pop   = inst_valid && inst_ready;

  assign rom_en     = issue;
  assign rom_addr   = pc_q;
  assign pc_next    = pc_q + StepVal;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? data_mem_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= StRun;
      inflight_q <= issue;
      if (issue) begin
        pc_q       <= pc_next;
        issue_pc_q <= pc_q;
      end
      if (do_redirect) begin
        // Flush wins over any same-cycle push or pop.
        pc_q     <= redirect_pc & AlignMask;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= rom_data;
      pc_mem_q[wr_ptr_q]   <= issue_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_next;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .pc_next       (pc_next)
  );

  // ROM word i lives at byte address 4*i and holds i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

  // Reference model: FIFO of PCs awaiting delivery, one pending response, fetch PC.
  logic [31:0] mq[$];
  bit          m_run = 0;
  bit          m_inflight = 0;
  logic [31:0] m_inflight_pc = '0;
  logic [31:0] m_pc = RESET_PC;

  always @(posedge clk) begin
    bit issue;
    bit pop;
    if (!rst) begin
      mq.delete();
      m_inflight = 0;
      m_pc = RESET_PC;
      m_run = 0;
    end else begin
      issue = m_run && fetch_en && !redirect_valid &&
              ((mq.size() + int'(m_inflight)) < int'(DEPTH));
      pop = (mq.size() != 0) && inst_ready;
      if (m_run && redirect_valid) begin
        mq.delete();
        m_inflight = 0;
        m_pc = redirect_pc & ~(32'(PC_STEP - 1));
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_inflight) mq.push_back(m_inflight_pc);
        m_inflight = issue;
        if (issue) begin
          m_inflight_pc = m_pc;
          m_pc = m_pc + 32'(PC_STEP);
        end
      end
      m_run = 1;
    end
  end

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rom_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    n_cmp++; if (inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin
      n_bad++; $display("FAIL reset_inst got %h want 0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    n_cmp++; if (rom_addr !== RESET_PC) begin
      n_bad++; $display("FAIL reset_rom_addr got %h want %h", rom_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    @(posedge clk); #1;
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (rom_en !== 1'b1) begin
        n_bad++; $display("FAIL stream_rom_en c=%0d got %b want 1", c, rom_en); end
      n_cmp++; if (rom_addr !== 32'(4 * (c - 1))) begin
        n_bad++; $display("FAIL stream_rom_addr c=%0d got %h want %h", c, rom_addr, 4 * (c - 1)); end
      n_cmp++; if (inst_valid !== (c >= 3)) begin
        n_bad++; $display("FAIL stream_valid c=%0d got %b want %b", c, inst_valid, c >= 3); end
      if (c >= 3) begin
        n_cmp++; if (inst !== 32'(c - 3) || inst_pc !== 32'(4 * (c - 3))) begin
          n_bad++; $display("FAIL stream_inst c=%0d got %h/%h want %h/%h",
                            c, inst, inst_pc, c - 3, 4 * (c - 3)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int got;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (rom_en !== 1'b0) begin
      n_bad++; $display("FAIL bp_rom_en got %b want 0", rom_en); end
    fetch_en = 1'b0; inst_ready = 1'b1;
    exp = mq[0];
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!inst_valid) break;
      n_cmp++; if (inst_pc !== exp || inst !== rom_word(exp)) begin
        n_bad++; $display("FAIL bp_drain i=%0d got %h/%h want %h/%h",
                          i, inst, inst_pc, rom_word(exp), exp); end
      exp = exp + 32'(PC_STEP);
      got++;
      @(posedge clk); #1;
    end
    n_cmp++; if (got != int'(DEPTH)) begin
      n_bad++; $display("FAIL bp_count got %0d want %0d", got, DEPTH); end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++; $display("FAIL %s_timeout got no inst_valid want 1", name);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    @(posedge clk); #1;
    fetch_en = 1'b1; inst_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mq.size() == 3) begin ok = 1; break; end
    end
    n_cmp++; if (!ok || inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL redir_fill got valid=%b want 3 buffered", inst_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1;
    redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_flush got %b want 0", inst_valid); end
    n_cmp++; if (rom_addr !== 32'h100 || rom_en !== 1'b1) begin
      n_bad++; $display("FAIL redir_addr got %h/%b want 100/1", rom_addr, rom_en); end
    wait_valid("redir", ok);
    if (ok) begin
      n_cmp++; if (inst_pc !== 32'h100 || inst !== 32'h40) begin
        n_bad++; $display("FAIL redir_first got %h/%h want 40/100", inst, inst_pc); end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_addr !== 32'hFFFF_FFFC || rom_en !== 1'b1) begin
      n_bad++; $display("FAIL wrap_addr got %h/%b want fffffffc/1", rom_addr, rom_en); end
    n_cmp++; if (pc_next !== 32'h0) begin
      n_bad++; $display("FAIL wrap_pc_next got %h want 0", pc_next); end
    @(negedge clk);
    n_cmp++; if (rom_addr !== 32'h0) begin
      n_bad++; $display("FAIL wrap_next_addr got %h want 0", rom_addr); end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h3FFF_FFFF) begin
      n_bad++; $display("FAIL wrap_inst0 got %b %h/%h want 1 3fffffff/fffffffc",
                        inst_valid, inst, inst_pc); end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin
      n_bad++; $display("FAIL wrap_inst1 got %b %h/%h want 1 0/0", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    @(negedge clk);
    fetch_en = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mq.size() == 2 && m_inflight) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok || inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_setup got valid=%b want 2 buffered + 1 inflight", inst_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rom_en !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
                 inst_pc !== 32'h0 || rom_addr !== RESET_PC) begin
      n_bad++; $display("FAIL rstmid_outputs got en=%b v=%b %h/%h addr=%h want 0 0 0/0 %h",
                        rom_en, inst_valid, inst, inst_pc, rom_addr, RESET_PC); end
    wait_valid("rstmid", ok);
    if (ok) begin
      n_cmp++; if (inst_pc !== RESET_PC || inst !== rom_word(RESET_PC)) begin
        n_bad++; $display("FAIL rstmid_first got %h/%h want %h/%h",
                          inst, inst_pc, rom_word(RESET_PC), RESET_PC); end
    end
  endtask

  task automatic test_random();
    bit          exp_en;
    bit          have_last = 0;
    logic [31:0] last_pc = '0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      fetch_en = 1'($urandom_range(0, 1));
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc = $urandom;
      @(negedge clk);
      exp_en = m_run && fetch_en && !redirect_valid &&
               ((mq.size() + int'(m_inflight)) < int'(DEPTH));
      n_cmp++; if (rom_en !== exp_en || rom_addr !== m_pc) begin
        n_bad++; $display("FAIL rand_issue i=%0d got %b/%h want %b/%h",
                          i, rom_en, rom_addr, exp_en, m_pc); end
      n_cmp++; if (pc_next !== m_pc + 32'(PC_STEP)) begin
        n_bad++; $display("FAIL rand_pc_next i=%0d got %h want %h", i, pc_next, m_pc + 4); end
      n_cmp++; if (inst_valid !== (mq.size() != 0)) begin
        n_bad++; $display("FAIL rand_valid i=%0d got %b want %b", i, inst_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_cmp++; if (inst_pc !== mq[0] || inst !== rom_word(mq[0])) begin
          n_bad++; $display("FAIL rand_head i=%0d got %h/%h want %h/%h",
                            i, inst, inst_pc, rom_word(mq[0]), mq[0]); end
      end
      if (inst_valid && inst_ready) begin
        if (have_last) begin
          n_cmp++; if (inst_pc !== last_pc + 32'(PC_STEP)) begin
            n_bad++; $display("FAIL rand_contig i=%0d got %h want %h",
                              i, inst_pc, last_pc + 4); end
        end
        last_pc = inst_pc;
        have_last = 1;
      end
      if (redirect_valid) have_last = 0;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
